// File: rtl/measure_ctrl.sv
// measure_ctrl
// Oscilloscope cursor measurement controller. A request picks either the
// time cursors (x pair) or the voltage cursors (y pair) of one of two waves,
// takes the absolute cursor distance and scales it by that wave's sample-rate
// or vertical shrink setting using a 7-step shift-add multiplier.
//
// Ports
//   clock                     system clock, rising edge active
//   resetn                    asynchronous active-low reset
//   start                     measurement request, only looked at while idle
//   measurement[2:0]          1 = time (x cursors), 2 = voltage (y cursors)
//   waveSel[1:0]              0 = wave 1, 1 = wave 2
//   cursorx1/x2, cursory1/y2  11-bit cursor pixel positions
//   sampleadjust1/2           6-bit per-wave sample-rate setting
//   shiftDown1/2              4-bit per-wave vertical shrink setting
//   busy                      high while a measurement is running
//   done                      one-cycle pulse whenever num/overflow/error change
//   num[13:0]                 measurement result
//   overflow                  product did not fit in 14 bits (saturating build)
//   error                     last request was invalid
//
// Build option
//   MEASURE_CTRL_SAT_EN       when defined, results above 16383 saturate and
//                             raise overflow; otherwise the product is
//                             truncated to 14 bits and overflow stays low.
module measure_ctrl (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic [2:0]  measurement,
    input  logic [1:0]  waveSel,
    input  logic [10:0] cursorx1,
    input  logic [10:0] cursorx2,
    input  logic [10:0] cursory1,
    input  logic [10:0] cursory2,
    input  logic [5:0]  sampleadjust1,
    input  logic [5:0]  sampleadjust2,
    input  logic [3:0]  shiftDown1,
    input  logic [3:0]  shiftDown2,
    output logic        busy,
    output logic        done,
    output logic [13:0] num,
    output logic        overflow,
    output logic        error
);

    typedef enum logic [1:0] {IDLE, DIFF, MUL, SAT} stateT;

    stateT       state;
    stateT       nextState;

    logic        reqValid;
    logic        useX;
    logic [10:0] selA;
    logic [10:0] selB;
    logic [6:0]  scaleSel;

    logic [10:0] curA;
    logic [10:0] curB;
    logic [10:0] absDiff;
    logic [6:0]  multiplier;
    logic [17:0] mcand;
    logic [17:0] acc;
    logic [2:0]  bitCnt;

    logic [13:0] resultNum;
    logic        resultOvf;

    // Decode the live request. Only the selected cursor pair and the selected
    // wave's scale factor are captured, which is all the later stages need,
    // so input changes during a run cannot disturb it.
    always_comb begin
        reqValid = ((measurement == 3'd1) || (measurement == 3'd2)) && !waveSel[1];
        useX     = (measurement == 3'd1);
        selA     = useX ? cursorx1 : cursory1;
        selB     = useX ? cursorx2 : cursory2;
        scaleSel = 7'd0;
        if (useX) begin
            scaleSel = {1'b0, (waveSel[0] ? sampleadjust2 : sampleadjust1)} + 7'd1;
        end else begin
            scaleSel = ({3'b000, (waveSel[0] ? shiftDown2 : shiftDown1)} + 7'd1) << 1;
        end
    end

    // Subtract the smaller cursor from the larger so the distance never wraps.
    always_comb begin
        absDiff = (curA >= curB) ? (curA - curB) : (curB - curA);
    end

    // Final result shaping; saturate or truncate depending on the build.
    always_comb begin
`ifdef MEASURE_CTRL_SAT_EN
        if (acc > 18'd16383) begin
            resultNum = 14'd16383;
            resultOvf = 1'b1;
        end else begin
            resultNum = acc[13:0];
            resultOvf = 1'b0;
        end
`else
        resultNum = 14'(acc);
        resultOvf = 1'b0;
`endif
    end

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic. The multiply stage runs exactly seven times, one
    // multiplier bit per cycle, before the result is published.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (start && reqValid) nextState = DIFF;
            DIFF: nextState = MUL;
            MUL:  if (bitCnt == 3'd6) nextState = SAT;
            SAT:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Output decode: busy covers every non-idle state.
    always_comb begin
        busy = (state != IDLE);
    end

    // Datapath and published results. done defaults low so it is only ever a
    // single-cycle pulse, both for finished and for rejected requests.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            curA       <= '0;
            curB       <= '0;
            multiplier <= '0;
            mcand      <= '0;
            acc        <= '0;
            bitCnt     <= '0;
            done       <= 1'b0;
            num        <= '0;
            overflow   <= 1'b0;
            error      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (reqValid) begin
                            curA       <= selA;
                            curB       <= selB;
                            multiplier <= scaleSel;
                        end else begin
                            num      <= '0;
                            overflow <= 1'b0;
                            error    <= 1'b1;
                            done     <= 1'b1;
                        end
                    end
                end
                DIFF: begin
                    mcand  <= {7'd0, absDiff};
                    acc    <= '0;
                    bitCnt <= '0;
                end
                MUL: begin
                    if (multiplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand      <= mcand << 1;
                    multiplier <= multiplier >> 1;
                    bitCnt     <= bitCnt + 3'd1;
                end
                SAT: begin
                    num      <= resultNum;
                    overflow <= resultOvf;
                    error    <= 1'b0;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_measure_ctrl.sv
// tb_measure_ctrl
// Self-checking bench for measure_ctrl. Expected results come from a plain
// arithmetic model of the measurement rules (distance times scale factor,
// then saturate or truncate), independent of how the design iterates.
module tb_measure_ctrl;

    logic        clock;
    logic        resetn;
    logic        start;
    logic [2:0]  measurement;
    logic [1:0]  waveSel;
    logic [10:0] cursorx1;
    logic [10:0] cursorx2;
    logic [10:0] cursory1;
    logic [10:0] cursory2;
    logic [5:0]  sampleadjust1;
    logic [5:0]  sampleadjust2;
    logic [3:0]  shiftDown1;
    logic [3:0]  shiftDown2;
    logic        busy;
    logic        done;
    logic [13:0] num;
    logic        overflow;
    logic        error;

    int checks;
    int failures;

    int heldNum;
    int heldOvf;
    int heldErr;

    int expNum;
    int expOvf;
    int expErr;
    bit expAccept;

    measure_ctrl dut (
        .clock        (clock),
        .resetn       (resetn),
        .start        (start),
        .measurement  (measurement),
        .waveSel      (waveSel),
        .cursorx1     (cursorx1),
        .cursorx2     (cursorx2),
        .cursory1     (cursory1),
        .cursory2     (cursory2),
        .sampleadjust1(sampleadjust1),
        .sampleadjust2(sampleadjust2),
        .shiftDown1   (shiftDown1),
        .shiftDown2   (shiftDown2),
        .busy         (busy),
        .done         (done),
        .num          (num),
        .overflow     (overflow),
        .error        (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: what the current inputs should produce if accepted.
    function automatic void modelRequest();
        int d;
        int scale;
        int product;
        expAccept = ((measurement == 3'd1) || (measurement == 3'd2)) && (waveSel <= 2'd1);
        expNum = 0;
        expOvf = 0;
        expErr = 1;
        if (expAccept) begin
            if (measurement == 3'd1) begin
                d     = int'(cursorx1) - int'(cursorx2);
                scale = ((waveSel == 2'd0) ? int'(sampleadjust1) : int'(sampleadjust2)) + 1;
            end else begin
                d     = int'(cursory1) - int'(cursory2);
                scale = 2 * (((waveSel == 2'd0) ? int'(shiftDown1) : int'(shiftDown2)) + 1);
            end
            if (d < 0) d = -d;
            product = d * scale;
            expErr = 0;
`ifdef MEASURE_CTRL_SAT_EN
            if (product > 16383) begin
                expNum = 16383;
                expOvf = 1;
            end else begin
                expNum = product;
                expOvf = 0;
            end
`else
            expNum = product % 16384;
            expOvf = 0;
`endif
        end
    endfunction

    task automatic applyStimulus(input int meas, input int ws, input int x1, input int x2,
                                 input int y1, input int y2, input int sa1, input int sa2,
                                 input int sd1, input int sd2);
        measurement   = 3'(meas);
        waveSel       = 2'(ws);
        cursorx1      = 11'(x1);
        cursorx2      = 11'(x2);
        cursory1      = 11'(y1);
        cursory2      = 11'(y2);
        sampleadjust1 = 6'(sa1);
        sampleadjust2 = 6'(sa2);
        shiftDown1    = 4'(sd1);
        shiftDown2    = 4'(sd2);
    endtask

    task automatic randomValid();
        int x1;
        int y1;
        x1 = int'($urandom_range(0, 2047));
        y1 = int'($urandom_range(0, 2047));
        applyStimulus(int'($urandom_range(1, 2)), int'($urandom_range(0, 1)),
                      x1, ($urandom_range(0, 7) == 0) ? x1 : int'($urandom_range(0, 2047)),
                      y1, ($urandom_range(0, 7) == 0) ? y1 : int'($urandom_range(0, 2047)),
                      int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                      int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    endtask

    task automatic randomInvalid();
        randomValid();
        if ($urandom_range(0, 1) == 0) begin
            measurement = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(3, 7));
        end else begin
            waveSel = 2'($urandom_range(2, 3));
        end
    endtask

    // Issue one request and follow it to its done pulse. If intrudeAt is
    // nonzero, a second start with different inputs lands on that edge
    // after the accepting edge and must be ignored.
    task automatic runRequest(input string name, input int intrudeAt);
        int k;
        bit heldBad;
        modelRequest();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        if (!expAccept) begin
            checks++;
            if (done !== 1'b1 || busy !== 1'b0 || num !== 14'(expNum) || error !== 1'b1 || overflow !== 1'b0) begin
                failures++;
                $display("[TB] FAIL %s reject: done=%b busy=%b num=%0d ovf=%b err=%b, expected done=1 busy=0 num=0 ovf=0 err=1",
                         name, done, busy, num, overflow, error);
            end
        end else begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("[TB] FAIL %s accept: busy=%b done=%b, expected busy=1 done=0", name, busy, done);
            end
            k = 0;
            heldBad = 1'b0;
            while (done !== 1'b1 && k < 30) begin
                @(posedge clock);
                #1;
                k++;
                if (intrudeAt != 0 && k == intrudeAt - 1) begin
                    randomValid();
                    start = 1'b1;
                end
                if (intrudeAt != 0 && k == intrudeAt) start = 1'b0;
                if (done !== 1'b1 && (num !== 14'(heldNum) || overflow !== 1'(heldOvf) || error !== 1'(heldErr)))
                    heldBad = 1'b1;
            end
            start = 1'b0;
            checks++;
            if (k != 9) begin
                failures++;
                $display("[TB] FAIL %s latency: got %0d edges after accept, expected 9", name, k);
            end
            checks++;
            if (heldBad) begin
                failures++;
                $display("[TB] FAIL %s hold: outputs changed before done, expected num=%0d held", name, heldNum);
            end
            checks++;
            if (num !== 14'(expNum) || overflow !== 1'(expOvf) || error !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("[TB] FAIL %s result: num=%0d ovf=%b err=%b busy=%b, expected num=%0d ovf=%0d err=0 busy=0",
                         name, num, overflow, error, busy, expNum, expOvf);
            end
        end
        heldNum = expNum;
        heldOvf = expOvf;
        heldErr = expErr;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || num !== 14'(heldNum)) begin
                failures++;
                $display("[TB] FAIL %s after: done=%b busy=%b num=%0d, expected done=0 busy=0 num=%0d",
                         name, done, busy, num, heldNum);
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || num !== 14'd0 || overflow !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset state: busy=%b done=%b num=%0d ovf=%b err=%b, expected all 0",
                     busy, done, num, overflow, error);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        heldNum = 0;
        heldOvf = 0;
        heldErr = 0;
    endtask

    task automatic test_directed();
        applyStimulus(2, 0, 0, 0, 100, 40, 0, 0, 3, 0);
        runRequest("volt_w1", 0);
        applyStimulus(1, 1, 10, 250, 0, 0, 0, 4, 0, 0);
        runRequest("time_w2", 0);
        applyStimulus(1, 1, 250, 10, 0, 0, 0, 4, 0, 0);
        runRequest("time_w2_swapped", 0);
        applyStimulus(1, 0, 0, 2047, 0, 0, 63, 0, 0, 0);
        runRequest("time_max", 0);
        applyStimulus(2, 1, 0, 0, 777, 777, 0, 0, 0, 15);
        runRequest("equal_cursors", 0);
        applyStimulus(2, 1, 0, 0, 2047, 0, 0, 0, 0, 15);
        runRequest("volt_max", 0);
    endtask

    task automatic test_invalid();
        applyStimulus(0, 0, 5, 9, 5, 9, 1, 1, 1, 1);
        runRequest("meas_none", 0);
        applyStimulus(1, 1, 10, 250, 0, 0, 0, 4, 0, 0);
        runRequest("before_bad_wave", 0);
        applyStimulus(1, 3, 10, 250, 0, 0, 0, 4, 0, 0);
        runRequest("bad_wave", 0);
        applyStimulus(6, 0, 10, 250, 0, 0, 0, 4, 0, 0);
        runRequest("bad_meas", 0);
    endtask

    task automatic test_ignore_start();
        applyStimulus(2, 0, 0, 0, 100, 40, 0, 0, 3, 0);
        runRequest("ignore_start", 3);
    endtask

    task automatic test_back_to_back();
        int k;
        randomValid();
        modelRequest();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        for (int r = 0; r < 2; r++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("[TB] FAIL b2b accept %0d: busy=%b done=%b, expected busy=1 done=0", r, busy, done);
            end
            k = 0;
            while (done !== 1'b1 && k < 30) begin
                @(posedge clock);
                #1;
                k++;
            end
            checks++;
            if (k != 9 || num !== 14'(expNum) || overflow !== 1'(expOvf) || error !== 1'b0) begin
                failures++;
                $display("[TB] FAIL b2b result %0d: edges=%0d num=%0d ovf=%b err=%b, expected edges=9 num=%0d ovf=%0d err=0",
                         r, k, num, overflow, error, expNum, expOvf);
            end
            if (r == 0) begin
                @(posedge clock);
                #1;
            end
        end
        start = 1'b0;
        heldNum = expNum;
        heldOvf = expOvf;
        heldErr = 0;
        @(posedge clock);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b release: busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid();
        bit sawDone;
        applyStimulus(2, 0, 0, 0, 100, 40, 0, 0, 3, 0);
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        resetn = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || num !== 14'd0 || overflow !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid reset: busy=%b done=%b num=%0d ovf=%b err=%b, expected all 0",
                     busy, done, num, overflow, error);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        heldNum = 0;
        heldOvf = 0;
        heldErr = 0;
        sawDone = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clock);
            #1;
            if (done !== 1'b0 || busy !== 1'b0) sawDone = 1'b1;
        end
        checks++;
        if (sawDone) begin
            failures++;
            $display("[TB] FAIL abort: activity after aborted request, expected busy=0 done=0 throughout");
        end
        applyStimulus(1, 0, 300, 50, 0, 0, 9, 0, 0, 0);
        runRequest("after_reset", 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 4) == 0) randomInvalid();
            else randomValid();
            runRequest("random", 0);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        resetn   = 1'b1;
        start    = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        test_reset();
        test_directed();
        test_invalid();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
